// File: rtl/decode_buffer_pkg.sv
// decode_buffer_pkg: shared control/instruction definitions for the decode buffer.
// Holds the decoded control bundle (control_t), exception flags (exc_t),
// the writeback value selectors (including VAL_HI/VAL_LO) and the opcode/funct codes.
package decode_buffer_pkg;

    typedef enum logic [3:0] {
        ALU_PLUS, ALU_MINUS, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_e;

    typedef enum logic [1:0] {SRC_B_REG, SRC_B_IMM_S, SRC_B_IMM_Z} src_b_e;

    typedef enum logic [1:0] {REG_DST_RT, REG_DST_RD, REG_DST_RA} reg_dst_e;

    typedef enum logic [3:0] {
        BR_NONE, BR_EQ, BR_NE, BR_LEZ, BR_GTZ, BR_LTZ, BR_GEZ, BR_J, BR_JR
    } branch_e;

    typedef enum logic [3:0] {
        MEM_NONE, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW
    } mem_op_e;

    typedef enum logic [2:0] {VAL_ALU, VAL_MEM, VAL_PC8, VAL_HI, VAL_LO} val_sel_e;

    typedef enum logic [2:0] {
        HILO_NONE, HILO_MULT, HILO_MULTU, HILO_DIV, HILO_DIVU, HILO_MTHI, HILO_MTLO
    } hilo_op_e;

    // Every "none" encoding is zero, so an all-zero bundle is a nop.
    typedef struct packed {
        alu_op_e  alu_op;
        src_b_e   src_b;
        reg_dst_e reg_dst;
        logic     reg_write_en;
        logic     shamt;
        branch_e  branch;
        mem_op_e  mem_op;
        val_sel_e val_sel;
        hilo_op_e hilo_op;
    } control_t;

    typedef struct packed {
        logic ri;
        logic sys;
        logic brk;
    } exc_t;

    localparam control_t CTRL_NOP = '0;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR = 6'h08, FN_JALR = 6'h09, FN_SYSCALL = 6'h0C, FN_BREAK = 6'h0D;
    localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13;
    localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1A, FN_DIVU = 6'h1B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

endpackage

// File: rtl/decode_buffer_if.sv
// decode_buffer_if: fetch-side and execute-side handshakes of the decode buffer.
//   in_valid/in_ready/in_pc/in_instr       : fetch offers an instruction
//   out_valid/out_ready/out_pc/out_instr,
//   out_ctrl/out_exc                       : head entry presented to execute
// The slave modport is the buffer; the master modport is the fetch/execute side.
interface decode_buffer_if;
    import decode_buffer_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    control_t    out_ctrl;
    exc_t        out_exc;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_ctrl, out_exc
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_ctrl, out_exc
    );

endinterface

// File: rtl/decode_buffer_decode_logic.sv
// decode_logic: combinational MIPS-I decoder, instruction word -> control bundle + exception flags.
//   instr : raw instruction word
//   ctrl  : decoded control bundle (nop for reserved/trap instructions)
//   exc   : ri/sys/brk, at most one set
// EN_MULDIV=0 turns the HI/LO multiply/divide group into reserved instructions.
module decode_logic
    import decode_buffer_pkg::*;
#(
    parameter bit EN_MULDIV = 1'b1
) (
    input  logic [31:0] instr,
    output control_t    ctrl,
    output exc_t        exc
);

    logic [5:0] op, fn;
    logic [4:0] rt;
    logic       md, unused_bits;

    assign op = instr[31:26];
    assign rt = instr[20:16];
    assign fn = instr[5:0];
    // HI/LO group occupies funct 0x10-0x13 and 0x18-0x1B.
    assign md = (op == OP_SPECIAL) && (fn[5:2] == 4'b0100 || fn[5:2] == 4'b0110);
    assign unused_bits = ^{instr[25:21], instr[15:6]};

    always_comb begin
        ctrl = CTRL_NOP;
        exc  = '0;
        case (op)
            OP_SPECIAL: begin
                ctrl.reg_dst      = REG_DST_RD;
                ctrl.reg_write_en = 1'b1;
                case (fn)
                    FN_SLL:            begin ctrl.alu_op = ALU_SLL; ctrl.shamt = 1'b1; end
                    FN_SRL:            begin ctrl.alu_op = ALU_SRL; ctrl.shamt = 1'b1; end
                    FN_SRA:            begin ctrl.alu_op = ALU_SRA; ctrl.shamt = 1'b1; end
                    FN_SLLV:           ctrl.alu_op = ALU_SLL;
                    FN_SRLV:           ctrl.alu_op = ALU_SRL;
                    FN_SRAV:           ctrl.alu_op = ALU_SRA;
                    FN_JR:             begin ctrl.reg_write_en = 1'b0; ctrl.branch = BR_JR; end
                    FN_JALR:           begin ctrl.branch = BR_JR; ctrl.val_sel = VAL_PC8; end
                    FN_SYSCALL:        begin ctrl = CTRL_NOP; exc.sys = 1'b1; end
                    FN_BREAK:          begin ctrl = CTRL_NOP; exc.brk = 1'b1; end
                    FN_MFHI:           ctrl.val_sel = VAL_HI;
                    FN_MFLO:           ctrl.val_sel = VAL_LO;
                    FN_MTHI:           begin ctrl.reg_write_en = 1'b0; ctrl.hilo_op = HILO_MTHI; end
                    FN_MTLO:           begin ctrl.reg_write_en = 1'b0; ctrl.hilo_op = HILO_MTLO; end
                    FN_MULT:           begin ctrl.reg_write_en = 1'b0; ctrl.hilo_op = HILO_MULT; end
                    FN_MULTU:          begin ctrl.reg_write_en = 1'b0; ctrl.hilo_op = HILO_MULTU; end
                    FN_DIV:            begin ctrl.reg_write_en = 1'b0; ctrl.hilo_op = HILO_DIV; end
                    FN_DIVU:           begin ctrl.reg_write_en = 1'b0; ctrl.hilo_op = HILO_DIVU; end
                    FN_ADD, FN_ADDU:   ctrl.alu_op = ALU_PLUS;
                    FN_SUB, FN_SUBU:   ctrl.alu_op = ALU_MINUS;
                    FN_AND:            ctrl.alu_op = ALU_AND;
                    FN_OR:             ctrl.alu_op = ALU_OR;
                    FN_XOR:            ctrl.alu_op = ALU_XOR;
                    FN_NOR:            ctrl.alu_op = ALU_NOR;
                    FN_SLT:            ctrl.alu_op = ALU_SLT;
                    FN_SLTU:           ctrl.alu_op = ALU_SLTU;
                    default:           begin ctrl = CTRL_NOP; exc.ri = 1'b1; end
                endcase
            end
            OP_REGIMM: begin
                // rt: 0x00 BLTZ, 0x01 BGEZ, 0x10 BLTZAL, 0x11 BGEZAL; bit 4 selects link.
                ctrl.branch       = rt[0] ? BR_GEZ : BR_LTZ;
                ctrl.reg_write_en = rt[4];
                ctrl.reg_dst      = rt[4] ? REG_DST_RA : REG_DST_RT;
                ctrl.val_sel      = rt[4] ? VAL_PC8 : VAL_ALU;
                if (rt[3:1] != 3'b000) begin
                    ctrl   = CTRL_NOP;
                    exc.ri = 1'b1;
                end
            end
            OP_J:     ctrl.branch = BR_J;
            OP_JAL:   begin ctrl.branch = BR_J; ctrl.reg_write_en = 1'b1; ctrl.reg_dst = REG_DST_RA; ctrl.val_sel = VAL_PC8; end
            OP_BEQ:   ctrl.branch = BR_EQ;
            OP_BNE:   ctrl.branch = BR_NE;
            OP_BLEZ:  ctrl.branch = BR_LEZ;
            OP_BGTZ:  ctrl.branch = BR_GTZ;
            OP_ADDIU: begin ctrl.alu_op = ALU_PLUS; ctrl.src_b = SRC_B_IMM_S; ctrl.reg_write_en = 1'b1; end
            OP_SLTI:  begin ctrl.alu_op = ALU_SLT;  ctrl.src_b = SRC_B_IMM_S; ctrl.reg_write_en = 1'b1; end
            OP_SLTIU: begin ctrl.alu_op = ALU_SLTU; ctrl.src_b = SRC_B_IMM_S; ctrl.reg_write_en = 1'b1; end
            OP_ANDI:  begin ctrl.alu_op = ALU_AND;  ctrl.src_b = SRC_B_IMM_Z; ctrl.reg_write_en = 1'b1; end
            OP_ORI:   begin ctrl.alu_op = ALU_OR;   ctrl.src_b = SRC_B_IMM_Z; ctrl.reg_write_en = 1'b1; end
            OP_XORI:  begin ctrl.alu_op = ALU_XOR;  ctrl.src_b = SRC_B_IMM_Z; ctrl.reg_write_en = 1'b1; end
            OP_LUI:   begin ctrl.alu_op = ALU_LUI;  ctrl.src_b = SRC_B_IMM_Z; ctrl.reg_write_en = 1'b1; end
            OP_LB:    begin ctrl.src_b = SRC_B_IMM_S; ctrl.reg_write_en = 1'b1; ctrl.val_sel = VAL_MEM; ctrl.mem_op = MEM_LB; end
            OP_LBU:   begin ctrl.src_b = SRC_B_IMM_S; ctrl.reg_write_en = 1'b1; ctrl.val_sel = VAL_MEM; ctrl.mem_op = MEM_LBU; end
            OP_LH:    begin ctrl.src_b = SRC_B_IMM_S; ctrl.reg_write_en = 1'b1; ctrl.val_sel = VAL_MEM; ctrl.mem_op = MEM_LH; end
            OP_LHU:   begin ctrl.src_b = SRC_B_IMM_S; ctrl.reg_write_en = 1'b1; ctrl.val_sel = VAL_MEM; ctrl.mem_op = MEM_LHU; end
            OP_LW:    begin ctrl.src_b = SRC_B_IMM_S; ctrl.reg_write_en = 1'b1; ctrl.val_sel = VAL_MEM; ctrl.mem_op = MEM_LW; end
            OP_SB:    begin ctrl.src_b = SRC_B_IMM_S; ctrl.mem_op = MEM_SB; end
            OP_SH:    begin ctrl.src_b = SRC_B_IMM_S; ctrl.mem_op = MEM_SH; end
            OP_SW:    begin ctrl.src_b = SRC_B_IMM_S; ctrl.mem_op = MEM_SW; end
            default:  exc.ri = 1'b1;
        endcase
        if (md && !EN_MULDIV) begin
            ctrl   = CTRL_NOP;
            exc    = '0;
            exc.ri = 1'b1;
        end
    end

endmodule

// File: rtl/decode_buffer.sv
// decode_buffer: circular buffer between fetch and execute that decodes on push.
//   clk, resetn : clock and synchronous active-low reset
//   flush       : drops every held entry and the word offered this cycle
//   bus         : decode_buffer_if slave (fetch push side, execute pop side)
//   count       : number of held entries
// Parameters: DEPTH (power of two, 2..16), EN_MULDIV (HI/LO group decoded or reserved).
module decode_buffer
    import decode_buffer_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit EN_MULDIV = 1'b1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    decode_buffer_if.slave         bus,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0] pc_q    [DEPTH];
    logic [31:0] instr_q [DEPTH];
    control_t    ctrl_q  [DEPTH];
    exc_t        exc_q   [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    control_t dec_ctrl;
    exc_t     dec_exc;
    logic     push, pop;

    decode_logic #(.EN_MULDIV(EN_MULDIV)) u_decode (
        .instr (bus.in_instr),
        .ctrl  (dec_ctrl),
        .exc   (dec_exc)
    );

    assign bus.in_ready  = count != CW'(DEPTH);
    assign bus.out_valid = count != '0;
    assign push = bus.in_valid & bus.in_ready & ~flush;
    assign pop  = bus.out_valid & bus.out_ready & ~flush;

    assign bus.out_pc    = bus.out_valid ? pc_q[rd_ptr] : '0;
    assign bus.out_instr = bus.out_valid ? instr_q[rd_ptr] : '0;
    assign bus.out_ctrl  = bus.out_valid ? ctrl_q[rd_ptr] : CTRL_NOP;
    assign bus.out_exc   = bus.out_valid ? exc_q[rd_ptr] : '0;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
                ctrl_q[i]  <= CTRL_NOP;
                exc_q[i]   <= '0;
            end
        end else if (push) begin
            pc_q[wr_ptr]    <= bus.in_pc;
            instr_q[wr_ptr] <= bus.in_instr;
            ctrl_q[wr_ptr]  <= dec_ctrl;
            exc_q[wr_ptr]   <= dec_exc;
        end
    end

endmodule

// File: doc/decode_buffer.md
DECODE_BUFFER -- requirements
Module: decode_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: entry count, power of two, 2..16.
REQ-002 SHALL have parameter EN_MULDIV, default 1: when 1, HI/LO multiply/divide group decoded; when 0, that group flagged reserved.
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port resetn  in  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  in  1  fetch offers an instruction.
REQ-006 SHALL have port in_ready  out  1  buffer accepts this cycle.
REQ-007 SHALL have port in_pc  in  32  PC of offered instruction.
REQ-008 SHALL have port in_instr  in  32  raw instruction word.
REQ-009 SHALL have port flush  in  1  discard all held entries (branch/exception redirect).
REQ-010 SHALL have port out_valid  out  1  head entry present.
REQ-011 SHALL have port out_ready  in  1  execute consumes head.
REQ-012 SHALL have ports out_pc, out_instr  out  32 each  head PC and word.
REQ-013 SHALL have port out_ctrl  out  control_t  head decoded control bundle.
REQ-014 SHALL have port out_exc  out  exc_t (3 bits: ri, sys, brk)  head exception flags.
REQ-015 SHALL have port count  out  $clog2(DEPTH)+1  entries held.

Function
REQ-016 SHALL decode at push time (combinational on in_instr), storing pc, instr, ctrl, exc per entry; no decode on the output side.
REQ-017 SHALL decode the existing ISA set (R-type ALU/shift, JR/JALR, REGIMM BGEZ/BLTZ/BGEZAL/BLTZAL, BEQ/BNE/BGTZ/BLEZ, J/JAL, ADDIU/ANDI/ORI/XORI/LUI/SLTI/SLTIU, LB/LBU/LH/LHU/LW, SB/SH/SW) to the same control_t encodings.
REQ-018 SHALL, with EN_MULDIV=1, decode MULT/MULTU/DIV/DIVU (hilo write, no GPR write) and MFHI/MFLO (GPR rd write, value VAL_HI/VAL_LO) and MTHI/MTLO via new control_t field hilo_op.
REQ-019 SHALL decode SYSCALL (funct 0x0C) and BREAK (funct 0x0D) as nop control with sys=1 or brk=1 respectively.
REQ-020 SHALL emit nop control and ri=1 for any unlisted opcode, funct or REGIMM rt code; exactly one of ri/sys/brk set, or none.
REQ-021 SHALL set push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
REQ-022 SHALL drive in_ready = (count != DEPTH), independent of out_ready (no full-state pass-through).
REQ-023 SHALL drive out_valid = (count != 0); out_* from head entry, zero when empty.
REQ-024 SHALL give one-cycle latency: an entry pushed at edge N is visible at the outputs after edge N.
REQ-025 SHALL keep count unchanged on simultaneous push and pop, increment on push only, decrement on pop only.
REQ-026 SHALL wrap read/write pointers modulo DEPTH; wrap SHALL not corrupt order.
REQ-027 SHALL, on flush, set count=0 and both pointers to 0 at the next edge; flush dominates push and pop in the same cycle.
REQ-028 SHALL hold head outputs stable while out_valid=1 and out_ready=0.

Reset
REQ-029 SHALL, when resetn=0 at a rising edge, clear count, pointers and all stored control to nop; in_ready=1, out_valid=0, out_* = 0 after that edge.
REQ-030 SHALL discard in-flight entries on reset mid-operation, identically to flush.

Structure
REQ-031 SHALL place control_t (extended with hilo_op), exc_t, VAL_HI/VAL_LO, FN_MULT..FN_MTLO, FN_SYSCALL, FN_BREAK in the shared control/instr package.
REQ-032 SHALL split decode into one combinational sub-module decode_logic (instr -> ctrl, exc, EN_MULDIV parameter); the buffer holds storage and pointers.

Verification
REQ-033 SHALL check: push 0x24080005 (addiu $t0,$0,5) into empty buffer -> next cycle out_valid=1, alu_op PLUS, src_b IMM_S, reg_dst RT, reg_write_en=1, exc=0.
REQ-034 SHALL check: out_ready=0, push 4 words with DEPTH=4 -> count=4, in_ready=0; 5th offer not accepted; pop order equals push order.
REQ-035 SHALL check: push 0x0000000C -> sys=1, nop control; push 0xFC000000 -> ri=1; push 0x00850018 (mult) with EN_MULDIV=0 -> ri=1, with EN_MULDIV=1 -> ri=0, hilo_op MULT.
REQ-036 SHALL check: count=3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, offered word dropped.
REQ-037 SHALL check: 10 back-to-back push/pop with out_ready=1 -> pointer wrap, count stays 1, PCs 0xBFC00000+4k emerge in order.
REQ-038 SHALL check: resetn=0 for one cycle while count=2 -> next cycle count=0, out_valid=0, in_ready=1.
